reg_scoreboard_ctrl: RTL and testbench

Issue-stage scheduler for the register-file write port in the pipelined MIPS core. It tracks every architectural register with an outstanding write, stalls issue on RAW/WAW hazards, and drives the RegDst select of the 5-bit 2:1 destination mux.
Each accepted instruction's destination (rt or rd) is marked busy and released on writeback. The block also keeps hazard statistics and flags protocol errors.

---
 rtl/reg_scoreboard_ctrl_pkg.sv | 10 +
 rtl/reg_scoreboard_ctrl_if.sv | 40 ++++
 rtl/reg_scoreboard_ctrl_bits.sv | 31 +++
 rtl/reg_scoreboard_ctrl.sv | 98 +++++++++
 tb/tb_reg_scoreboard_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/reg_scoreboard_ctrl_pkg.sv
// Shared constants for the register-file write-port scoreboard.
package reg_scoreboard_ctrl_pkg;
    localparam int MIPS_AW   = 5;
    localparam int MIPS_NREG = 32;
    localparam int MIPS_CNTW = 16;

    localparam logic [4:0] REG_ZERO  = 5'd0;
    localparam logic       REGDST_RT = 1'b0;
    localparam logic       REGDST_RD = 1'b1;
endpackage

// File: rtl/reg_scoreboard_ctrl_if.sv
// Issue/writeback bus between decode, writeback and the scoreboard.
interface reg_scoreboard_ctrl_if
    import reg_scoreboard_ctrl_pkg::*;
#(
    parameter int AW   = MIPS_AW,
    parameter int NREG = MIPS_NREG,
    parameter int CNTW = MIPS_CNTW
);
    logic            Flush;
    logic            IssueValid;
    logic [AW-1:0]   IssueRs;
    logic [AW-1:0]   IssueRt;
    logic [AW-1:0]   IssueRd;
    logic            IssueRegDst;
    logic            IssueRegWrite;
    logic            WbValid;
    logic [AW-1:0]   WbReg;
    logic            Stall;
    logic            RegDstSel;
    logic            IssueFire;
    logic [AW-1:0]   IssueDest;
    logic [NREG-1:0] Busy;
    logic [AW:0]     Outstanding;
    logic [CNTW-1:0] StallCount;
    logic            WbErr;

    modport master (
        output Flush, IssueValid, IssueRs, IssueRt, IssueRd, IssueRegDst,
               IssueRegWrite, WbValid, WbReg,
        input  Stall, RegDstSel, IssueFire, IssueDest, Busy, Outstanding,
               StallCount, WbErr
    );

    modport slave (
        input  Flush, IssueValid, IssueRs, IssueRt, IssueRd, IssueRegDst,
               IssueRegWrite, WbValid, WbReg,
        output Stall, RegDstSel, IssueFire, IssueDest, Busy, Outstanding,
               StallCount, WbErr
    );
endinterface

// File: rtl/reg_scoreboard_ctrl_bits.sv
// Busy-bit vector: one set and one clear port per cycle, set wins on collision.
module scoreboard_bits #(
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_flush,
    input  logic            i_set,
    input  logic [AW-1:0]   i_set_idx,
    input  logic            i_clr,
    input  logic [AW-1:0]   i_clr_idx,
    output logic [NREG-1:0] o_busy
);
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_next;

    always_comb begin
        w_next = r_busy;
        if (i_clr) w_next[i_clr_idx] = 1'b0;
        if (i_set) w_next[i_set_idx] = 1'b1;
        w_next[0] = 1'b0;  // r0 is hardwired, never has a producer
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) r_busy <= '0;
        else                    r_busy <= w_next;
    end

    assign o_busy = r_busy;
endmodule

// File: rtl/reg_scoreboard_ctrl.sv
// Issue-stage RAW/WAW scoreboard for the register-file write port, with
// RegDst mux select, stall statistics and writeback protocol error flag.
module reg_scoreboard_ctrl
    import reg_scoreboard_ctrl_pkg::*;
#(
    parameter int NREG = MIPS_NREG,
    parameter int AW   = MIPS_AW,
    parameter int CNTW = MIPS_CNTW
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    reg_scoreboard_ctrl_if.slave io
);
    logic [AW-1:0]   w_dest;
    logic            w_wr;
    logic            w_stall;
    logic            w_accept;
    logic            w_set;
    logic            w_clr;
    logic            w_inc;
    logic            w_dec;
    logic            w_wb_err;
    logic [NREG-1:0] w_busy;
    logic [NREG-1:0] w_wb_hot;
    logic [NREG-1:0] w_eb;

    logic            r_fire;
    logic            r_sel;
    logic            r_err;
    logic [AW-1:0]   r_dest;
    logic [AW:0]     r_out;
    logic [CNTW-1:0] r_cnt;

    // A writeback in the same cycle hides the busy bit from the hazard check.
    always_comb begin
        w_wb_hot = '0;
        if (io.WbValid) w_wb_hot[io.WbReg] = 1'b1;
        w_eb    = w_busy & ~w_wb_hot;
        w_eb[0] = 1'b0;
    end

    assign w_dest   = (io.IssueRegDst == REGDST_RD) ? io.IssueRd : io.IssueRt;
    assign w_wr     = io.IssueRegWrite && (w_dest != AW'(REG_ZERO));
    assign w_stall  = io.IssueValid &&
                      (w_eb[io.IssueRs] || w_eb[io.IssueRt] || (w_wr && w_eb[w_dest]));
    assign w_accept = io.IssueValid && !w_stall && !io.Flush;
    assign w_set    = w_accept && w_wr;
    assign w_clr    = io.WbValid && (io.WbReg != AW'(REG_ZERO)) && !io.Flush;
    assign w_wb_err = w_clr && !w_busy[io.WbReg];

    // Counter tracks the popcount exactly: a set onto a bit being cleared is net zero.
    assign w_inc = w_set && !w_busy[w_dest];
    assign w_dec = w_clr && w_busy[io.WbReg] && !(w_set && (w_dest == io.WbReg));

    scoreboard_bits #(
        .NREG (NREG),
        .AW   (AW)
    ) u_bits (
        .i_clk     (i_Clk),
        .i_reset   (i_Reset),
        .i_flush   (io.Flush),
        .i_set     (w_set),
        .i_set_idx (w_dest),
        .i_clr     (w_clr),
        .i_clr_idx (io.WbReg),
        .o_busy    (w_busy)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_fire <= 1'b0;
            r_sel  <= REGDST_RT;
            r_dest <= '0;
            r_out  <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            r_fire <= w_accept;
            if (w_accept) begin
                r_dest <= w_wr ? w_dest : AW'(REG_ZERO);
                r_sel  <= io.IssueRegDst;
            end
            if (io.Flush) r_out <= '0;
            else          r_out <= r_out + (AW+1)'(w_inc) - (AW+1)'(w_dec);
            if (w_stall && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
            if (w_wb_err) r_err <= 1'b1;
        end
    end

    assign io.Stall       = w_stall;
    assign io.RegDstSel   = r_sel;
    assign io.IssueFire   = r_fire;
    assign io.IssueDest   = r_dest;
    assign io.Busy        = w_busy;
    assign io.Outstanding = r_out;
    assign io.StallCount  = r_cnt;
    assign io.WbErr       = r_err;
endmodule

// File: tb/tb_reg_scoreboard_ctrl.sv
// Directed scoreboard bench: issue stimulus pushes expected accepts, a
// negedge monitor pops them whenever IssueFire is presented.
module tb_reg_scoreboard_ctrl;
    logic clk;
    logic reset;

    typedef struct {
        logic [4:0] dest;
        logic       sel;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    reg_scoreboard_ctrl_if #(.AW(5), .NREG(32), .CNTW(16)) bus();

    reg_scoreboard_ctrl #(.NREG(32), .AW(5), .CNTW(16)) dut (
        .i_Clk   (clk),
        .i_Reset (reset),
        .io      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.Flush         = 1'b0;
        bus.IssueValid    = 1'b0;
        bus.IssueRs       = '0;
        bus.IssueRt       = '0;
        bus.IssueRd       = '0;
        bus.IssueRegDst   = 1'b0;
        bus.IssueRegWrite = 1'b0;
        bus.WbValid       = 1'b0;
        bus.WbReg         = '0;
    endtask

    task automatic set_issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic dst, input logic wr);
        bus.IssueValid    = 1'b1;
        bus.IssueRs       = rs;
        bus.IssueRt       = rt;
        bus.IssueRd       = rd;
        bus.IssueRegDst   = dst;
        bus.IssueRegWrite = wr;
    endtask

    // Hazard-free issue: expects no stall and an accept with the given outcome.
    task automatic issue_ok(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic dst, input logic wr, input logic [4:0] exp_dest);
        exp_t e;
        set_issue(rs, rt, rd, dst, wr);
        #1;
        check("stall_free_issue", 64'(bus.Stall), 64'd0);
        e.dest = exp_dest;
        e.sel  = dst;
        exp_q.push_back(e);
        tick();
        idle();
    endtask

    task automatic wb(input logic [4:0] r);
        bus.WbValid = 1'b1;
        bus.WbReg   = r;
        tick();
        idle();
    endtask

    always @(negedge clk) begin
        if (bus.IssueFire) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL fire_unexpected: got IssueFire=1 dest=%0d expected no accept", bus.IssueDest);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("fire_dest", 64'(bus.IssueDest), 64'(e.dest));
                check("fire_regdstsel", 64'(bus.RegDstSel), 64'(e.sel));
            end
        end
    end

    initial begin
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
        check("rst_busy", 64'(bus.Busy), 64'd0);
        check("rst_outstanding", 64'(bus.Outstanding), 64'd0);
        check("rst_stallcount", 64'(bus.StallCount), 64'd0);
        check("rst_wberr", 64'(bus.WbErr), 64'd0);
        check("rst_fire", 64'(bus.IssueFire), 64'd0);
        check("rst_dest", 64'(bus.IssueDest), 64'd0);
        check("rst_sel", 64'(bus.RegDstSel), 64'd0);
        check("rst_stall", 64'(bus.Stall), 64'd0);

        // R-type add $3,$1,$2
        issue_ok(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd3);
        check("r3_busy", 64'(bus.Busy), 64'h8);
        check("r3_outstanding", 64'(bus.Outstanding), 64'd1);
        check("r3_fire", 64'(bus.IssueFire), 64'd1);

        // WAW and RAW-on-rt hazards, observed combinationally only
        set_issue(5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
        #1 check("waw_stall", 64'(bus.Stall), 64'd1);
        set_issue(5'd1, 5'd3, 5'd4, 1'b1, 1'b1);
        #1 check("raw_rt_stall", 64'(bus.Stall), 64'd1);
        set_issue(5'd1, 5'd3, 5'd4, 1'b1, 1'b1);
        bus.WbValid = 1'b1;
        bus.WbReg   = 5'd3;
        #1 check("raw_rt_wb_bypass", 64'(bus.Stall), 64'd0);
        idle();
        tick();
        check("no_fire_when_idle", 64'(bus.IssueFire), 64'd0);

        // RAW on rs for 3 cycles, then same-cycle writeback releases it
        set_issue(5'd3, 5'd0, 5'd3, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1 check("raw_rs_stall", 64'(bus.Stall), 64'd1);
            tick();
        end
        check("stallcount_3", 64'(bus.StallCount), 64'd3);
        bus.WbValid = 1'b1;
        bus.WbReg   = 5'd3;
        begin
            exp_t e;
            #1 check("wb_release_stall", 64'(bus.Stall), 64'd0);
            e.dest = 5'd3;
            e.sel  = 1'b1;
            exp_q.push_back(e);
        end
        tick();
        idle();
        check("setwins_busy", 64'(bus.Busy), 64'h8);
        check("setwins_outstanding", 64'(bus.Outstanding), 64'd1);
        check("setwins_wberr", 64'(bus.WbErr), 64'd0);
        check("setwins_stallcount", 64'(bus.StallCount), 64'd3);

        // I-type with rt=0: write discarded, sources r0 never stall
        issue_ok(5'd0, 5'd0, 5'd9, 1'b0, 1'b1, 5'd0);
        check("r0_busy", 64'(bus.Busy), 64'h8);
        check("r0_outstanding", 64'(bus.Outstanding), 64'd1);

        // Busy={3,5,9}, then flush with a clean issue and a stray writeback
        issue_ok(5'd0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5);
        issue_ok(5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 5'd9);
        check("pre_flush_busy", 64'(bus.Busy), 64'h228);
        check("pre_flush_outstanding", 64'(bus.Outstanding), 64'd3);
        set_issue(5'd1, 5'd2, 5'd4, 1'b1, 1'b1);
        bus.Flush   = 1'b1;
        bus.WbValid = 1'b1;
        bus.WbReg   = 5'd12;
        #1 check("flush_issue_stall", 64'(bus.Stall), 64'd0);
        tick();
        idle();
        check("flush_busy", 64'(bus.Busy), 64'd0);
        check("flush_outstanding", 64'(bus.Outstanding), 64'd0);
        check("flush_fire", 64'(bus.IssueFire), 64'd0);
        check("flush_stallcount", 64'(bus.StallCount), 64'd3);
        check("flush_wberr", 64'(bus.WbErr), 64'd0);
        check("flush_dest_hold", 64'(bus.IssueDest), 64'd9);
        check("flush_sel_hold", 64'(bus.RegDstSel), 64'd1);

        // Writeback to r0 is ignored; to an idle r7 is a protocol error
        wb(5'd0);
        check("wb_r0_noerr", 64'(bus.WbErr), 64'd0);
        wb(5'd7);
        check("wberr_set", 64'(bus.WbErr), 64'd1);
        check("wberr_busy", 64'(bus.Busy), 64'd0);
        check("wberr_outstanding", 64'(bus.Outstanding), 64'd0);
        issue_ok(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd3);
        wb(5'd3);
        check("wberr_sticky", 64'(bus.WbErr), 64'd1);
        check("release_busy", 64'(bus.Busy), 64'd0);
        check("release_outstanding", 64'(bus.Outstanding), 64'd0);

        // Saturate the stall counter, then reset mid-stall with r3 busy
        issue_ok(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd3);
        set_issue(5'd3, 5'd0, 5'd4, 1'b1, 1'b1);
        repeat ((1 << 16) + 3) tick();
        check("sat_stallcount", 64'(bus.StallCount), 64'hFFFF);
        check("sat_stall", 64'(bus.Stall), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        check("rst2_busy", 64'(bus.Busy), 64'd0);
        check("rst2_outstanding", 64'(bus.Outstanding), 64'd0);
        check("rst2_stallcount", 64'(bus.StallCount), 64'd0);
        check("rst2_wberr", 64'(bus.WbErr), 64'd0);
        check("rst2_fire", 64'(bus.IssueFire), 64'd0);
        check("rst2_dest", 64'(bus.IssueDest), 64'd0);
        check("rst2_sel", 64'(bus.RegDstSel), 64'd0);
        tick();
        tick();
        check("exp_queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
